glip_bb_host_bridge: RTL and testbench

- Host-side initiator on the Blackbone external bus of the MPSoC.
- Accepts read/write command frames on a 16-bit GLIP-style valid/ready input stream.
- Issues single-word Blackbone accesses with an auto-incrementing address.
- Returns read data or a write acknowledge on a 16-bit valid/ready output stream.
- Gives the debug host direct memory access to external-bus targets without going through a core.

---
 rtl/glip_bb_host_bridge.sv | 149 ++++++++++++++
 tb/tb_glip_bb_host_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glip_bb_host_bridge.sv
// rtl/glip_bb_host_bridge.sv - GLIP command stream to Blackbone single-word initiator.
// Frames: header {we, ignored, len}, addr hi, addr lo, then len data words on writes.
module glip_bb_host_bridge #(
  parameter int ADDR_WIDTH   = 16,
  parameter int ADDR_INC     = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           glip_in_data,
  input  logic                  glip_in_valid,
  output logic                  glip_in_ready,
  output logic [15:0]           glip_out_data,
  output logic                  glip_out_valid,
  input  logic                  glip_out_ready,
  output logic [ADDR_WIDTH-1:0] bb_addr_o,
  output logic [15:0]           bb_dout_o,
  output logic                  bb_en_o,
  output logic [1:0]            bb_we_o,
  input  logic [15:0]           bb_din_i,
  output logic                  busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, WR_DATA, WR_ISSUE, WR_ACK, RD_ISSUE, RD_WAIT, RD_SEND
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(ADDR_INC);
  localparam logic [2:0]            WAIT_LAST = 3'(READ_LATENCY - 1);

  state_t                  state, state_d;
  logic                    hdr_write, hdr_write_d;
  logic [7:0]              hdr_len, hdr_len_d;
  logic [15:0]             addr_hi, addr_hi_d;
  logic [ADDR_WIDTH-1:0]   addr, addr_d;
  logic [8:0]              remaining, remaining_d;
  logic [2:0]              wait_cnt, wait_cnt_d;
  logic [15:0]             rdata;
  logic                    sample_rd;
  logic [31:0]             addr_full;
  logic                    unused_addr_bits;

  assign addr_full        = {addr_hi, glip_in_data};
  assign unused_addr_bits = ^addr_full[31:ADDR_WIDTH];

  assign busy_o         = (state != IDLE);
  assign bb_en_o        = (state == WR_ISSUE) || (state == RD_ISSUE);
  assign glip_out_valid = (state == WR_ACK) || (state == RD_SEND);
  assign glip_out_data  = (state == WR_ACK) ? {8'h80, hdr_len} : rdata;
  assign sample_rd      = (state == RD_WAIT) && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_d       = state;
    hdr_write_d   = hdr_write;
    hdr_len_d     = hdr_len;
    addr_hi_d     = addr_hi;
    addr_d        = addr;
    remaining_d   = remaining;
    wait_cnt_d    = wait_cnt;
    glip_in_ready = 1'b0;
    case (state)
      IDLE: begin
        glip_in_ready = 1'b1;
        if (glip_in_valid) begin
          hdr_write_d = glip_in_data[15];
          hdr_len_d   = glip_in_data[7:0];
          state_d     = ADDR_HI;
        end
      end
      ADDR_HI: begin
        glip_in_ready = 1'b1;
        if (glip_in_valid) begin
          addr_hi_d = glip_in_data;
          state_d   = ADDR_LO;
        end
      end
      ADDR_LO: begin
        glip_in_ready = 1'b1;
        if (glip_in_valid) begin
          addr_d      = addr_full[ADDR_WIDTH-1:0];
          // A zero length field encodes a 256-word burst.
          remaining_d = (hdr_len == 8'd0) ? 9'd256 : {1'b0, hdr_len};
          state_d     = hdr_write ? WR_DATA : RD_ISSUE;
        end
      end
      WR_DATA: begin
        glip_in_ready = 1'b1;
        if (glip_in_valid) state_d = WR_ISSUE;
      end
      WR_ISSUE: begin
        addr_d      = addr + ADDR_STEP;
        remaining_d = remaining - 9'd1;
        state_d     = (remaining == 9'd1) ? WR_ACK : WR_DATA;
      end
      WR_ACK: begin
        if (glip_out_ready) state_d = IDLE;
      end
      RD_ISSUE: begin
        wait_cnt_d = 3'd0;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        if (sample_rd) state_d = RD_SEND;
        else           wait_cnt_d = wait_cnt + 3'd1;
      end
      RD_SEND: begin
        // The next bus read waits for the host to take this word.
        if (glip_out_ready) begin
          addr_d      = addr + ADDR_STEP;
          remaining_d = remaining - 9'd1;
          state_d     = (remaining == 9'd1) ? IDLE : RD_ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hdr_write <= 1'b0;
      hdr_len   <= 8'd0;
      addr_hi   <= 16'd0;
      addr      <= '0;
      remaining <= 9'd0;
      wait_cnt  <= 3'd0;
      rdata     <= 16'd0;
      bb_addr_o <= '0;
      bb_dout_o <= 16'd0;
      bb_we_o   <= 2'b00;
    end else begin
      state     <= state_d;
      hdr_write <= hdr_write_d;
      hdr_len   <= hdr_len_d;
      addr_hi   <= addr_hi_d;
      addr      <= addr_d;
      remaining <= remaining_d;
      wait_cnt  <= wait_cnt_d;
      if (sample_rd) rdata <= bb_din_i;
      if (state == WR_DATA && glip_in_valid) bb_dout_o <= glip_in_data;
      // Bus address/enables only move when an access starts, so they hold between strobes.
      if ((state_d == WR_ISSUE || state_d == RD_ISSUE) && state_d != state) begin
        bb_addr_o <= addr_d;
        bb_we_o   <= (state_d == WR_ISSUE) ? 2'b11 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_glip_bb_host_bridge.sv
// tb/tb_glip_bb_host_bridge.sv - randomized self-checking bench for glip_bb_host_bridge.
module tb_glip_bb_host_bridge;

  typedef struct packed {
    logic [15:0] a;
    logic [1:0]  we;
    logic [15:0] d;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] bb_din;
  logic        sel;

  logic        a_in_ready, a_out_valid, a_en, a_busy;
  logic [15:0] a_out_data, a_addr, a_dout;
  logic [1:0]  a_we;
  logic        b_in_ready, b_out_valid, b_en, b_busy;
  logic [15:0] b_out_data, b_addr, b_dout;
  logic [1:0]  b_we;

  logic        in_ready, out_valid, bb_en, busy;
  logic [15:0] out_data, bb_addr, bb_dout;
  logic [1:0]  bb_we;

  always #5 clk = ~clk;

  glip_bb_host_bridge #(.ADDR_WIDTH(16), .ADDR_INC(2), .READ_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst),
    .glip_in_data(in_data), .glip_in_valid(in_valid & ~sel), .glip_in_ready(a_in_ready),
    .glip_out_data(a_out_data), .glip_out_valid(a_out_valid), .glip_out_ready(out_ready & ~sel),
    .bb_addr_o(a_addr), .bb_dout_o(a_dout), .bb_en_o(a_en), .bb_we_o(a_we),
    .bb_din_i(bb_din), .busy_o(a_busy));

  glip_bb_host_bridge #(.ADDR_WIDTH(16), .ADDR_INC(2), .READ_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .glip_in_data(in_data), .glip_in_valid(in_valid & sel), .glip_in_ready(b_in_ready),
    .glip_out_data(b_out_data), .glip_out_valid(b_out_valid), .glip_out_ready(out_ready & sel),
    .bb_addr_o(b_addr), .bb_dout_o(b_dout), .bb_en_o(b_en), .bb_we_o(b_we),
    .bb_din_i(bb_din), .busy_o(b_busy));

  assign in_ready  = sel ? b_in_ready  : a_in_ready;
  assign out_valid = sel ? b_out_valid : a_out_valid;
  assign out_data  = sel ? b_out_data  : a_out_data;
  assign bb_en     = sel ? b_en        : a_en;
  assign bb_addr   = sel ? b_addr      : a_addr;
  assign bb_dout   = sel ? b_dout      : a_dout;
  assign bb_we     = sel ? b_we        : a_we;
  assign busy      = sel ? b_busy      : a_busy;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] mem [0:65535];
  bus_t        bus_q[$];
  logic [15:0] out_q[$];
  logic [16:0] pipe[$];
  logic [15:0] wq[$];
  int          viol;
  int          out_mode;
  int          hold_cnt;
  logic        prev_en, prev_stall;
  logic [15:0] last_addr, last_dout, prev_data;
  logic [1:0]  last_we;

  // Bus device, response sink and protocol watcher; everything observed away from posedge.
  always @(negedge clk) begin
    if (!rst) begin
      pipe.delete();
      for (int i = 0; i < (sel ? 3 : 1); i++) pipe.push_back(17'd0);
      prev_en = 0; prev_stall = 0; hold_cnt = 0;
      last_addr = 0; last_dout = 0; last_we = 0; prev_data = 0;
      out_ready = 0; bb_din = 0;
    end else begin
      logic [16:0] e;
      if (bb_en) begin
        bus_q.push_back({bb_addr, bb_we, bb_dout});
        if (bb_we == 2'b11) mem[bb_addr] = bb_dout;
        if (prev_en) viol++;
        last_addr = bb_addr; last_we = bb_we; last_dout = bb_dout;
      end else if (bb_addr !== last_addr || bb_we !== last_we || bb_dout !== last_dout) begin
        viol++;
      end
      prev_en = bb_en;
      pipe.push_back((bb_en && bb_we == 2'b00) ? {1'b1, mem[bb_addr]} : 17'd0);
      e = pipe.pop_front();
      bb_din = e[16] ? e[15:0] : 16'($urandom);
      if (prev_stall && (!out_valid || out_data !== prev_data)) viol++;
      case (out_mode)
        0: out_ready = 1;
        1: out_ready = 1'($urandom);
        default: begin
          if (out_valid && hold_cnt >= 10) out_ready = 1;
          else begin
            out_ready = 0;
            if (out_valid) hold_cnt++;
          end
        end
      endcase
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        hold_cnt = 0;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic send_word(input logic [15:0] w, output bit ok);
    int cyc = 0;
    ok = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if ($urandom_range(3) == 0) begin
        in_valid = 0;
        continue;
      end
      in_valid = 1;
      in_data  = w;
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_frame(input string name, input bit we, input int n, input logic [31:0] a);
    logic [15:0] words[$];
    bus_t        exp_bus[$];
    logic [15:0] exp_out[$];
    logic [15:0] ea;
    bit          ok;
    int          cyc;
    int          nb;
    bus_q.delete(); out_q.delete(); viol = 0;
    words.push_back({we, 7'($urandom), 8'(n)});
    words.push_back(a[31:16]);
    words.push_back(a[15:0]);
    for (int i = 0; i < n; i++) begin
      ea = a[15:0] + 16'(2 * i);
      if (we) begin
        words.push_back(wq[i]);
        exp_bus.push_back({ea, 2'b11, wq[i]});
      end else begin
        exp_bus.push_back({ea, 2'b00, 16'h0});
        exp_out.push_back(mem[ea]);
      end
    end
    if (we) exp_out.push_back({8'h80, 8'(n)});
    foreach (words[i]) begin
      send_word(words[i], ok);
      if (!ok) begin
        check({name, " in_timeout"}, 0, 1);
        break;
      end
    end
    @(negedge clk);
    in_valid = 0;
    cyc = 0;
    while (out_q.size() < exp_out.size() && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    check({name, " resp_count"}, out_q.size(), exp_out.size());
    check({name, " bus_count"}, bus_q.size(), exp_bus.size());
    check({name, " busy_end"}, busy, 0);
    nb = (bus_q.size() < exp_bus.size()) ? bus_q.size() : exp_bus.size();
    for (int i = 0; i < nb; i++) begin
      check($sformatf("%s bus_addr[%0d]", name, i), bus_q[i].a, exp_bus[i].a);
      check($sformatf("%s bus_we[%0d]", name, i), bus_q[i].we, exp_bus[i].we);
      if (we) check($sformatf("%s bus_dout[%0d]", name, i), bus_q[i].d, exp_bus[i].d);
    end
    for (int i = 0; i < out_q.size() && i < exp_out.size(); i++)
      check($sformatf("%s out[%0d]", name, i), out_q[i], exp_out[i]);
    check({name, " protocol"}, viol, 0);
  endtask

  task automatic do_reset(input logic s);
    @(negedge clk);
    rst = 0; in_valid = 0; sel = s;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0200] = 16'h1111; mem[16'h0202] = 16'h2222; mem[16'h0204] = 16'h3333;
    sel = 0; rst = 0; in_valid = 0; in_data = 0; out_mode = 0; viol = 0;
    repeat (3) @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst bb_en", bb_en, 0);
    check("rst bb_we", bb_we, 0);
    check("rst bb_addr", bb_addr, 0);
    check("rst bb_dout", bb_dout, 0);
    check("rst busy", busy, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    wq = '{16'hAAAA, 16'h5555};
    run_frame("wr2", 1, 2, 32'h0000_0100);
    run_frame("rd3", 0, 3, 32'h0000_0200);
    out_mode = 2;
    run_frame("rd3_bp", 0, 3, 32'h0000_0200);

    out_mode = 1;
    do_reset(1);
    run_frame("rd3_lat3", 0, 3, 32'h0000_0200);
    for (int k = 0; k < 4; k++) begin
      int n = $urandom_range(1, 8);
      bit w = 1'($urandom);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      out_mode = $urandom_range(0, 2);
      run_frame($sformatf("lat3_rand%0d", k), w, n, $urandom);
    end

    out_mode = 0;
    do_reset(0);
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(16'($urandom));
    run_frame("wr256_wrap", 1, 256, 32'h0000_FFFE);
    if (bus_q.size() == 256) begin
      check("wrap addr1", bus_q[1].a, 16'h0000);
      check("wrap last", bus_q[255].a, 16'h01FC);
    end else check("wrap size", bus_q.size(), 256);

    for (int k = 0; k < 6; k++) begin
      int n = $urandom_range(1, 8);
      bit w = 1'($urandom);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      out_mode = $urandom_range(0, 2);
      run_frame($sformatf("rand%0d", k), w, n, $urandom);
    end

    out_mode = 0;
    wq = '{16'h8004, 16'h0000, 16'h0300, 16'h1234, 16'h5678};
    foreach (wq[i]) send_word(wq[i], ok);
    @(negedge clk);
    rst = 0;
    #1;
    check("midrst bb_en", bb_en, 0);
    check("midrst bb_we", bb_we, 0);
    check("midrst bb_addr", bb_addr, 0);
    check("midrst bb_dout", bb_dout, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst out_data", out_data, 0);
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 1);
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    run_frame("post_rst_rd", 0, 1, 32'h0000_0010);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
